alu_seq: RTL and testbench

- Parametrised, registered successor to the single-cycle combinational ALU used in the datapath.
- Keeps the same 4-bit opcode map for codes 0000-1010 and adds iterative multiply and divide (codes 1011-1110).
- Both operand input and result output use valid/ready handshakes, so the block can stall the execute stage while a multi-cycle operation runs.
- Sits between the register-read stage and the writeback/forwarding logic.

---
 rtl/alu_seq.sv | 121 ++++++++++++
 tb/tb_alu_seq.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/alu_seq.sv
// Registered ALU with valid/ready handshakes: single-cycle ops complete in one edge,
// MUL/MULHU/DIVU/REMU iterate one bit per cycle over WIDTH cycles.
module alu_seq #(
  parameter int WIDTH = 32,
  parameter int SH_W  = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       alu_op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             busy
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  localparam logic [3:0] OP_MUL   = 4'b1011;
  localparam logic [3:0] OP_MULHU = 4'b1100;
  localparam logic [3:0] OP_DIVU  = 4'b1101;
  localparam logic [3:0] OP_REMU  = 4'b1110;

  state_t               state;
  logic [3:0]           op_r;
  logic [SH_W-1:0]      cnt;
  logic [2*WIDTH-1:0]   acc;   // mul: {partial hi, multiplier}; div: {remainder, quotient}
  logic [WIDTH-1:0]     opb;   // mul: multiplicand; div: divisor

  logic                 accept, is_multi, is_mul, op_r_mul;
  logic [WIDTH-1:0]     alu_res;
  logic [WIDTH:0]       msum, dshift;
  logic [WIDTH-1:0]     dtrial;
  logic                 dge;
  logic [2*WIDTH-1:0]   acc_nxt;
  logic [WIDTH-1:0]     iter_res;

  assign in_ready  = rst_n && (state == IDLE || (state == DONE && out_ready));
  assign accept    = in_valid && in_ready;
  assign is_multi  = (alu_op == OP_MUL) || (alu_op == OP_MULHU) ||
                     (alu_op == OP_DIVU) || (alu_op == OP_REMU);
  assign is_mul    = (alu_op == OP_MUL) || (alu_op == OP_MULHU);
  assign op_r_mul  = (op_r == OP_MUL) || (op_r == OP_MULHU);
  assign out_valid = (state == DONE);
  assign busy      = (state == BUSY);
  assign zero      = (result == '0);

  always_comb begin
    alu_res = '0;
    case (alu_op)
      4'b0000: alu_res = a + b;
      4'b0001: alu_res = a - b;
      4'b0010: alu_res = {{(WIDTH-1){1'b0}}, $signed(a) < $signed(b)};
      4'b0011: alu_res = {{(WIDTH-1){1'b0}}, a < b};
      4'b0100: alu_res = a & b;
      4'b0101: alu_res = a | b;
      4'b0110: alu_res = a ^ b;
      4'b0111: alu_res = ~(a | b);
      4'b1000: alu_res = a >> b[SH_W-1:0];
      4'b1001: alu_res = $signed(a) >>> b[SH_W-1:0];
      4'b1010: alu_res = a << b[SH_W-1:0];
      default: alu_res = '0;
    endcase
  end

  // One iteration step; divide-by-zero falls out naturally (quotient all-ones, remainder a).
  always_comb begin
    msum    = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opb} : '0);
    dshift  = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
    dge     = (dshift >= {1'b0, opb});
    dtrial  = dshift[WIDTH-1:0] - opb;
    if (op_r_mul)
      acc_nxt = {msum, acc[WIDTH-1:1]};
    else
      acc_nxt = {(dge ? dtrial : dshift[WIDTH-1:0]), acc[WIDTH-2:0], dge};
    case (op_r)
      OP_MULHU, OP_REMU: iter_res = acc_nxt[2*WIDTH-1:WIDTH];
      default:           iter_res = acc_nxt[WIDTH-1:0];
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      op_r   <= '0;
      cnt    <= '0;
      acc    <= '0;
      opb    <= '0;
      result <= '0;
    end else if (accept) begin
      op_r <= alu_op;
      if (is_multi) begin
        state <= BUSY;
        cnt   <= '0;
        acc   <= {{WIDTH{1'b0}}, (is_mul ? b : a)};
        opb   <= is_mul ? a : b;
      end else begin
        state  <= DONE;
        result <= alu_res;
      end
    end else begin
      case (state)
        BUSY: begin
          acc <= acc_nxt;
          cnt <= cnt + SH_W'(1);
          if (cnt == SH_W'(WIDTH-1)) begin
            state  <= DONE;
            result <= iter_res;
          end
        end
        DONE:    if (out_ready) state <= IDLE;
        default: state <= state;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq: directed scenarios plus randomized ops vs. an arithmetic model.
module tb_alu_seq;
  localparam int W = 32;

  logic         clk = 1'b0, rst_n = 1'b0;
  logic         in_valid = 1'b0, out_ready = 1'b0;
  logic [W-1:0] a = '0, b = '0;
  logic [3:0]   alu_op = '0;
  logic         in_ready, out_valid, zero, busy;
  logic [W-1:0] result;
  int           checks = 0, passed = 0;

  alu_seq #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .alu_op(alu_op), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .zero(zero), .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic logic [W-1:0] model(input logic [3:0] op, input logic [W-1:0] x, input logic [W-1:0] y);
    logic [2*W-1:0]      p;
    logic signed [W-1:0] sx;
    int                  sh;
    p  = {{W{1'b0}}, x} * {{W{1'b0}}, y};
    sx = x;
    sh = int'(y % W);
    case (op)
      4'd0:  return x + y;
      4'd1:  return x - y;
      4'd2:  return ($signed(x) < $signed(y)) ? 1 : 0;
      4'd3:  return (x < y) ? 1 : 0;
      4'd4:  return x & y;
      4'd5:  return x | y;
      4'd6:  return x ^ y;
      4'd7:  return ~(x | y);
      4'd8:  return x >> sh;
      4'd9:  return sx >>> sh;
      4'd10: return x << sh;
      4'd11: return p[W-1:0];
      4'd12: return p[2*W-1:W];
      4'd13: return (y == 0) ? '1 : x / y;
      4'd14: return (y == 0) ? x : x % y;
      default: return '0;
    endcase
  endfunction

  // Issue one op from IDLE, scramble inputs after acceptance, wait (bounded) for the result.
  task automatic run_op(input logic [3:0] op, input logic [W-1:0] x, input logic [W-1:0] y,
                        output logic [W-1:0] res, output logic zr, output int lat,
                        output int busy_cyc, output int rdy_hi);
    alu_op = op; a = x; b = y; in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; a = $urandom; b = $urandom; alu_op = 4'($urandom);
    lat = 1; busy_cyc = 0; rdy_hi = 0;
    while (!out_valid && lat < 200) begin
      if (busy) busy_cyc++;
      if (in_ready) rdy_hi++;
      @(posedge clk); #1;
      lat++;
    end
    res = result; zr = zero;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    logic [W-1:0] r; logic z; int lat, bc, rh;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (out_valid !== 1'b0 || result !== '0 || zero !== 1'b1 || busy !== 1'b0 || in_ready !== 1'b0)
      $display("FAIL reset_state: ov=%b res=%h z=%b busy=%b rdy=%b, want 0 0 1 0 0", out_valid, result, zero, busy, in_ready);
    else passed++;
    rst_n = 1'b1;
    @(posedge clk); #1;
    checks++; if (in_ready !== 1'b1) $display("FAIL reset_release_ready: got %b want 1", in_ready); else passed++;
    alu_op = 4'b1011; a = 7; b = 9; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (9) begin @(posedge clk); #1; end
    checks++; if (busy !== 1'b1) $display("FAIL mid_mul_busy: got %b want 1", busy); else passed++;
    rst_n = 1'b0; #1;
    checks++; if (out_valid !== 1'b0 || result !== '0 || zero !== 1'b1 || busy !== 1'b0)
      $display("FAIL mid_mul_reset: ov=%b res=%h z=%b busy=%b, want 0 0 1 0", out_valid, result, zero, busy);
    else passed++;
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
    run_op(4'b0000, 1, 1, r, z, lat, bc, rh);
    checks++; if (r !== 2 || lat !== 1) $display("FAIL post_reset_add: res=%h lat=%0d want 2 lat 1", r, lat); else passed++;
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b1;
    alu_op = 4'b0000; a = 5; b = 3; in_valid = 1'b1;
    @(posedge clk); #1;
    checks++; if (out_valid !== 1'b1 || result !== 32'd8) $display("FAIL b2b_add: ov=%b res=%h want 1 8", out_valid, result); else passed++;
    alu_op = 4'b0001; a = 3; b = 5;
    @(posedge clk); #1;
    checks++; if (out_valid !== 1'b1 || result !== 32'hFFFF_FFFE) $display("FAIL b2b_sub: ov=%b res=%h want 1 fffffffe", out_valid, result); else passed++;
    alu_op = 4'b1001; a = 32'h8000_0000; b = 4;
    @(posedge clk); #1;
    checks++; if (out_valid !== 1'b1 || result !== 32'hF800_0000) $display("FAIL b2b_sra: ov=%b res=%h want 1 f8000000", out_valid, result); else passed++;
    in_valid = 1'b0;
    @(posedge clk); #1;
    checks++; if (out_valid !== 1'b0) $display("FAIL b2b_drain: ov=%b want 0", out_valid); else passed++;
  endtask

  task automatic test_compare();
    logic [W-1:0] r; logic z; int lat, bc, rh;
    run_op(4'b0010, 32'hFFFF_FFFF, 1, r, z, lat, bc, rh);
    checks++; if (r !== 1 || lat !== 1) $display("FAIL slt: res=%h lat=%0d want 1 lat 1", r, lat); else passed++;
    run_op(4'b0011, 32'hFFFF_FFFF, 1, r, z, lat, bc, rh);
    checks++; if (r !== 0) $display("FAIL sltu: res=%h want 0", r); else passed++;
    run_op(4'b0001, 32'h1234, 32'h1234, r, z, lat, bc, rh);
    checks++; if (r !== 0 || z !== 1'b1) $display("FAIL sub_zero: res=%h z=%b want 0 1", r, z); else passed++;
  endtask

  task automatic test_mul();
    logic [W-1:0] r; logic z; int lat, bc, rh;
    run_op(4'b1011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, r, z, lat, bc, rh);
    checks++; if (r !== 32'h1 || z !== 1'b0) $display("FAIL mul_lo: res=%h z=%b want 00000001 0", r, z); else passed++;
    checks++; if (lat !== W+1 || bc !== W || rh !== 0)
      $display("FAIL mul_timing: lat=%0d busy=%0d rdy=%0d want %0d %0d 0", lat, bc, rh, W+1, W);
    else passed++;
    run_op(4'b1100, 32'hFFFF_FFFF, 32'hFFFF_FFFF, r, z, lat, bc, rh);
    checks++; if (r !== 32'hFFFF_FFFE) $display("FAIL mulhu: res=%h want fffffffe", r); else passed++;
  endtask

  task automatic test_div();
    logic [W-1:0] r; logic z; int lat, bc, rh;
    run_op(4'b1101, 100, 7, r, z, lat, bc, rh);
    checks++; if (r !== 14) $display("FAIL divu: res=%h want e", r); else passed++;
    run_op(4'b1110, 100, 7, r, z, lat, bc, rh);
    checks++; if (r !== 2) $display("FAIL remu: res=%h want 2", r); else passed++;
    run_op(4'b1101, 32'h55, 0, r, z, lat, bc, rh);
    checks++; if (r !== 32'hFFFF_FFFF || lat !== W+1) $display("FAIL divu_by0: res=%h lat=%0d want ffffffff %0d", r, lat, W+1); else passed++;
    run_op(4'b1110, 32'h55, 0, r, z, lat, bc, rh);
    checks++; if (r !== 32'h55 || lat !== W+1) $display("FAIL remu_by0: res=%h lat=%0d want 55 %0d", r, lat, W+1); else passed++;
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    alu_op = 4'b0000; a = 10; b = 20; in_valid = 1'b1;
    @(posedge clk); #1;
    alu_op = 4'b0110; a = 32'hF0; b = 32'hFF;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      checks++; if (out_valid !== 1'b1 || result !== 32'd30 || zero !== 1'b0 || in_ready !== 1'b0)
        $display("FAIL bp_hold%0d: ov=%b res=%h z=%b rdy=%b want 1 1e 0 0", i, out_valid, result, zero, in_ready);
      else passed++;
    end
    out_ready = 1'b1; #1;
    checks++; if (in_ready !== 1'b1) $display("FAIL bp_ready_comb: got %b want 1", in_ready); else passed++;
    @(posedge clk); #1;
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b1 || result !== 32'h0F) $display("FAIL bp_next: ov=%b res=%h want 1 f", out_valid, result); else passed++;
    @(posedge clk); #1;
  endtask

  task automatic test_random();
    logic [W-1:0] r, x, y, exp; logic z; logic [3:0] op; int lat, bc, rh, elat;
    for (int i = 0; i < 40; i++) begin
      op = 4'($urandom);
      x  = $urandom;
      case ($urandom_range(0, 3))
        0:       y = 0;
        1:       y = $urandom_range(1, 40);
        default: y = $urandom;
      endcase
      exp  = model(op, x, y);
      elat = (op >= 4'd11 && op <= 4'd14) ? W+1 : 1;
      run_op(op, x, y, r, z, lat, bc, rh);
      checks++; if (r !== exp || z !== (exp == 0) || lat !== elat)
        $display("FAIL rand%0d op=%h a=%h b=%h: res=%h z=%b lat=%0d want %h %b %0d", i, op, x, y, r, z, lat, exp, exp == 0, elat);
      else passed++;
    end
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_compare();
    test_mul();
    test_div();
    test_backpressure();
    test_random();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
